bbc_bus_scheduler: RTL and testbench
====================================

Name: bbc_bus_scheduler

Overview:
- Time-slices the shared system RAM between the MOS6502 core and the video fetch path.
- Generates the CPU `clk_en` strobe from the 16 MHz system clock.
- Stretches CPU cycles that address 1 MHz peripheral space so they align to the 1 MHz bus.
- Sits between the system clock root and the MOS6502 core's `clk_en`. It also drives the RAM address-mux select, the RAM write strobe and the 1 MHz peripheral enable.

Parameters:
- `SLOW_LO`, 16'hFC00, lowest address of the 1 MHz (stretched) region, inclusive.
- `SLOW_HI`, 16'hFEFF, highest address of the 1 MHz region, inclusive.
- `RAM_TOP`, 16'h7FFF, highest address decoded as RAM; RAM spans 0..`RAM_TOP`.

Ports:
- `clk` input 1: 16 MHz system clock; all state updates on the rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `cpu_addr` input 16: CPU `Address_bus`; stable from the cycle after a `cpu_clk_en` pulse.
- `cpu_rnw` input 1: CPU `RnW`.
- `halt` input 1: debug stall request, sampled at phase 0 only.
- `cpu_clk_en` output 1: one-`clk` CPU advance strobe.
- `cpu_phi2` output 1: high while the CPU owns RAM (phases 4-7).
- `ram_sel_vid` output 1: 1 = RAM address mux selects the video address; 0 = selects `cpu_addr`.
- `vid_en` output 1: one-`clk` strobe; video latches RAM read data.
- `ram_we` output 1: RAM write strobe.
- `one_mhz_en` output 1: one-`clk` 1 MHz peripheral clock enable.
- `stretching` output 1: high while the current 2 MHz cycle has `cpu_clk_en` suppressed.

Behaviour:
- **State.** 3-bit phase counter `ph` (0..7, wraps 7→0 every `clk`), giving a 2 MHz cycle.
  - Parity bit `p1` toggles when `ph` wraps 7→0.
  - A stall counter `stall_cnt` (2 bits) and a `halted` flag.
- **Output timing.** All outputs are decoded combinationally from registered state only; none depend combinationally on `cpu_addr`, `cpu_rnw` or `halt`.
- **Reset.** `ph`=0, `p1`=0, `stall_cnt`=0, `halted`=0. Resulting outputs:
  - `ram_sel_vid`=1.
  - `cpu_clk_en`=0, `cpu_phi2`=0, `vid_en`=0, `ram_we`=0, `one_mhz_en`=0, `stretching`=0.
- **Reset mid-cycle.** The in-progress cycle is abandoned with no `cpu_clk_en` or `ram_we`. The first possible `cpu_clk_en` after release is at `ph`=7 of the first cycle.
- **RAM slotting.**
  - `ram_sel_vid` = (`ph` ≤ 3).
  - `cpu_phi2` = (`ph` ≥ 4).
  - `vid_en` = (`ph` == 3).
- **Cycle classification** (registered at the `clk` edge where `ph` goes 0→1, from `cpu_addr`/`halt` held during `ph`=0):
  - `halt`=1: `halted`←1; `stretching` is high for the whole cycle; no `cpu_clk_en`. Re-evaluated every cycle.
  - Otherwise, if `stall_cnt`≠0: `stall_cnt` is kept; no re-sample.
  - Otherwise, if `SLOW_LO` ≤ `cpu_addr` ≤ `SLOW_HI`: `stall_cnt` ← 1 if `p1`=0, 2 if `p1`=1.
  - Otherwise: fast cycle.
- **Stall counting.** At `ph`=7 of a cycle with `stall_cnt`≠0, `stall_cnt` decrements and `cpu_clk_en` is suppressed.
  - `stretching` = (`stall_cnt`≠0 or `halted`), valid for `ph` 1..7.
- **`cpu_clk_en`** = (`ph`==7) & ~`halted` & (`stall_cnt`==0).
  - Fast access: exactly 1 cycle (8 `clk`).
  - Slow access: 2 cycles if started with `p1`=0, 3 cycles if started with `p1`=1.
  - Every slow access therefore completes at the end of a `p1`=1 cycle, coincident with `one_mhz_en`.
- **`one_mhz_en`** = (`ph`==7) & (`p1`==1). It is free-running and unaffected by stalls or halt.
- **`ram_we`** = ~`cpu_rnw` & (`ph` ∈ {5,6}) & (`cpu_addr` ≤ `RAM_TOP`, registered at `ph` 0→1) & ~`stretching`. RAM is never written during a stalled or halted cycle.
- **`halt` mid-slow-access.** `halt` is ignored until `stall_cnt` reaches 0, so a slow access always completes first.
- **Simultaneous events.** If `halt` and a slow address occur together at `ph`=0 with `stall_cnt`=0, halt wins. The slow stretch is evaluated in the first non-halted cycle using the `p1` current at that time.

Decomposition:
- Shared package `bbc_bus_pkg`:
  - Phase constants: `PH_VID_LATCH`=3, `PH_CPU_START`=4, `PH_WE_FIRST`=5, `PH_WE_LAST`=6, `PH_END`=7.
  - Default region bounds.
- One sub-module, `bbc_addr_region`: combinational, `cpu_addr` → `is_ram`, `is_slow`, parameterised on the bounds.
- Phase counter, stall logic and output decode stay in the top module.

Test Plan:
- **Reset release, fast fetch.** Release `RESET`, `cpu_addr`=16'h1234, `cpu_rnw`=1 → `cpu_clk_en` pulses at `clk` 7, 15, 23; `vid_en` at 3, 11, 19; `ram_we` never high.
- **RAM write.** `cpu_addr`=16'h2000, `cpu_rnw`=0 → `ram_we` high exactly at `ph` 5 and 6 of each cycle.
- **ROM write.** `cpu_addr`=16'hC000, `cpu_rnw`=0 → `ram_we`=0.
- **Slow access, even parity.** `cpu_addr`=16'hFE40 presented in a `p1`=0 cycle → `stretching` high for `ph` 1..7 of that cycle; `cpu_clk_en` only at the end of the next cycle, coincident with `one_mhz_en`. Total 16 `clk`.
- **Slow access, odd parity.** Same access started in a `p1`=1 cycle → two suppressed cycles; `cpu_clk_en` at the 24th `clk`, coincident with `one_mhz_en`.
- **Halt during slow stretch.** Assert `halt` during the odd-parity stretch → stretch completes with `cpu_clk_en`; then no `cpu_clk_en` while `halt`=1. `one_mhz_en` keeps pulsing every 16 `clk`. Resume on the first cycle after `halt`=0 is sampled at `ph`=0.
- **Async reset mid-write.** Assert `RESET` at `ph`=5 of a RAM write → `ram_we` falls immediately, without waiting for a `clk` edge; all outputs at reset values; no `cpu_clk_en` until `ph`=7 after release.

Source files
------------

// File: rtl/bbc_bus_pkg.sv
// Shared phase numbering and default address-region bounds for the bus scheduler.
package bbc_bus_pkg;

  // Phase numbers within one 8-clk (2 MHz) bus cycle
  localparam logic [2:0] PH_VID_LATCH = 3'd3;
  localparam logic [2:0] PH_CPU_START = 3'd4;
  localparam logic [2:0] PH_WE_FIRST  = 3'd5;
  localparam logic [2:0] PH_WE_LAST   = 3'd6;
  localparam logic [2:0] PH_END       = 3'd7;

  // Default memory map: RAM at the bottom, 1 MHz peripherals in FC00..FEFF
  localparam logic [15:0] DEF_SLOW_LO = 16'hFC00;
  localparam logic [15:0] DEF_SLOW_HI = 16'hFEFF;
  localparam logic [15:0] DEF_RAM_TOP = 16'h7FFF;

endpackage

// File: rtl/bbc_bus_scheduler_region.sv
// Address decode: classifies a CPU address as RAM and/or 1 MHz peripheral space.
module bbc_addr_region
  import bbc_bus_pkg::*;
#(
  parameter logic [15:0] SLOW_LO = DEF_SLOW_LO,
  parameter logic [15:0] SLOW_HI = DEF_SLOW_HI,
  parameter logic [15:0] RAM_TOP = DEF_RAM_TOP
) (
  input  logic [15:0] cpu_addr,
  output logic        is_ram,
  output logic        is_slow
);

  // Pure range compares; bounds are inclusive
  always_comb begin
    is_ram  = (cpu_addr <= RAM_TOP);
    is_slow = (cpu_addr >= SLOW_LO) && (cpu_addr <= SLOW_HI);
  end

endmodule

// File: rtl/bbc_bus_scheduler.sv
// Shares system RAM between video and CPU, generates the CPU clock enable and
// stretches CPU cycles that touch 1 MHz peripheral space.
module bbc_bus_scheduler
  import bbc_bus_pkg::*;
#(
  parameter logic [15:0] SLOW_LO = DEF_SLOW_LO,
  parameter logic [15:0] SLOW_HI = DEF_SLOW_HI,
  parameter logic [15:0] RAM_TOP = DEF_RAM_TOP
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic        halt,
  output logic        cpu_clk_en,
  output logic        cpu_phi2,
  output logic        ram_sel_vid,
  output logic        vid_en,
  output logic        ram_we,
  output logic        one_mhz_en,
  output logic        stretching
);

  logic [2:0] ph;
  logic       p1;
  logic [1:0] stall_cnt;
  logic       halted;
  // Set for the final (unsuppressed) cycle of a slow access so that the
  // still-held slow address is not classified a second time and a halt
  // request cannot cut the access short.
  logic       slow_done;
  logic       ram_q;
  logic       rnw_q;
  logic       is_ram;
  logic       is_slow;

  bbc_addr_region #(
    .SLOW_LO(SLOW_LO),
    .SLOW_HI(SLOW_HI),
    .RAM_TOP(RAM_TOP)
  ) u_region (
    .cpu_addr(cpu_addr),
    .is_ram  (is_ram),
    .is_slow (is_slow)
  );

  // Phase counter, parity, cycle classification at ph 0->1, stall countdown at ph 7
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      ph        <= 3'd0;
      p1        <= 1'b0;
      stall_cnt <= 2'd0;
      halted    <= 1'b0;
      slow_done <= 1'b0;
      ram_q     <= 1'b0;
      rnw_q     <= 1'b1;
    end else begin
      ph <= ph + 3'd1;
      if (ph == 3'd0) begin
        ram_q <= is_ram;
        rnw_q <= cpu_rnw;
        if (stall_cnt != 2'd0 || slow_done) begin
          halted <= 1'b0;
        end else if (halt) begin
          halted <= 1'b1;
        end else begin
          halted <= 1'b0;
          if (is_slow) stall_cnt <= p1 ? 2'd2 : 2'd1;
        end
      end
      if (ph == PH_END) begin
        p1 <= ~p1;
        if (stall_cnt != 2'd0) begin
          stall_cnt <= stall_cnt - 2'd1;
          slow_done <= (stall_cnt == 2'd1);
        end else begin
          slow_done <= 1'b0;
        end
      end
    end
  end

  // Output decode from registered state only
  always_comb begin
    stretching  = (stall_cnt != 2'd0) || halted;
    ram_sel_vid = (ph < PH_CPU_START);
    cpu_phi2    = (ph >= PH_CPU_START);
    vid_en      = (ph == PH_VID_LATCH);
    cpu_clk_en  = (ph == PH_END) && !halted && (stall_cnt == 2'd0);
    one_mhz_en  = (ph == PH_END) && p1;
    ram_we      = !rnw_q && ram_q && !stretching &&
                  (ph >= PH_WE_FIRST) && (ph <= PH_WE_LAST);
  end

endmodule

// File: tb/tb_bbc_bus_scheduler.sv
// Directed bench for bbc_bus_scheduler: cycle-by-cycle checks of every output
// against hand-derived expectations for fast, write, slow, halt and reset cases.
`timescale 1ns/1ps
module tb_bbc_bus_scheduler;

  logic        clk = 1'b0;
  logic        RESET;
  logic [15:0] cpu_addr;
  logic        cpu_rnw;
  logic        halt;
  logic        cpu_clk_en, cpu_phi2, ram_sel_vid, vid_en, ram_we, one_mhz_en, stretching;

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;   // clk edges since last reset release

  bbc_bus_scheduler dut (
    .clk        (clk),
    .RESET      (RESET),
    .cpu_addr   (cpu_addr),
    .cpu_rnw    (cpu_rnw),
    .halt       (halt),
    .cpu_clk_en (cpu_clk_en),
    .cpu_phi2   (cpu_phi2),
    .ram_sel_vid(ram_sel_vid),
    .vid_en     (vid_en),
    .ram_we     (ram_we),
    .one_mhz_en (one_mhz_en),
    .stretching (stretching)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s n=%0d got=%b exp=%b", tag, n, got, exp);
    end
  endtask

  // All outputs must show their reset values
  task automatic chk_reset(input string tag);
    chk({tag, "/ce"},   cpu_clk_en,  1'b0);
    chk({tag, "/phi2"}, cpu_phi2,    1'b0);
    chk({tag, "/sel"},  ram_sel_vid, 1'b1);
    chk({tag, "/vid"},  vid_en,      1'b0);
    chk({tag, "/we"},   ram_we,      1'b0);
    chk({tag, "/1m"},   one_mhz_en,  1'b0);
    chk({tag, "/str"},  stretching,  1'b0);
  endtask

  // One clk edge, then check all outputs. ce: CPU may advance this cycle;
  // we: a RAM write is in progress; str: cycle is stretched/halted.
  task automatic step(input string tag, input bit ce, input bit we, input bit str);
    int ph;
    bit p1;
    @(posedge clk);
    #1;
    n++;
    ph = n % 8;
    p1 = ((n / 8) % 2) == 1;
    chk({tag, "/ce"},   cpu_clk_en,  ce && ph == 7);
    chk({tag, "/phi2"}, cpu_phi2,    ph >= 4);
    chk({tag, "/sel"},  ram_sel_vid, ph <= 3);
    chk({tag, "/vid"},  vid_en,      ph == 3);
    chk({tag, "/1m"},   one_mhz_en,  ph == 7 && p1);
    chk({tag, "/we"},   ram_we,      we && (ph == 5 || ph == 6));
    if (ph != 0) chk({tag, "/str"}, stretching, str);
  endtask

  task automatic cyc(input string tag, input bit ce, input bit we, input bit str);
    for (int i = 0; i < 8; i++) step(tag, ce, we, str);
  endtask

  initial begin
    RESET = 1'b1; cpu_addr = 16'h1234; cpu_rnw = 1'b1; halt = 1'b0;
    @(posedge clk); #1;
    chk_reset("reset");
    @(posedge clk); #1;
    RESET = 1'b0;
    n = 0;

    // Cycles 0-2: fast reads, clk_en at edges 7/15/23
    for (int c = 0; c < 3; c++) cyc("fast", 1, 0, 0);

    // Cycles 3-4: RAM write
    cpu_addr = 16'h2000; cpu_rnw = 1'b0;
    cyc("ramwr", 1, 1, 0);
    cyc("ramwr", 1, 1, 0);

    // Cycle 5: ROM write, never strobes RAM
    cpu_addr = 16'hC000;
    cyc("romwr", 1, 0, 0);

    // Cycles 6-7: slow access from p1=0 -> one suppressed cycle
    cpu_addr = 16'hFE40; cpu_rnw = 1'b1;
    cyc("slow_even", 0, 0, 1);
    cyc("slow_even", 1, 0, 0);

    // Cycle 8: fast, to realign onto a p1=1 cycle
    cpu_addr = 16'h1234;
    cyc("fast2", 1, 0, 0);

    // Cycles 9-11: slow access from p1=1 -> two suppressed cycles;
    // halt raised mid-stretch must not disturb it
    cpu_addr = 16'hFE40;
    cyc("slow_odd", 0, 0, 1);
    halt = 1'b1;
    cyc("slow_odd_h", 0, 0, 1);
    cyc("slow_odd_h", 1, 0, 0);

    // Cycles 12-13: halted; a pending RAM write must not strobe
    cpu_addr = 16'h2000; cpu_rnw = 1'b0;
    cyc("halted", 0, 0, 1);
    cyc("halted", 0, 0, 1);

    // Cycle 14: resume after halt drops
    halt = 1'b0;
    cyc("resume", 1, 1, 0);

    // Cycle 15: halt and slow address together -> halt wins
    halt = 1'b1; cpu_addr = 16'hFE40; cpu_rnw = 1'b1;
    cyc("halt_slow", 0, 0, 1);
    // Cycles 16-17: slow evaluated with p1=0 -> one suppressed cycle
    halt = 1'b0;
    cyc("post_halt_slow", 0, 0, 1);
    cyc("post_halt_slow", 1, 0, 0);

    // Cycle 18: RAM write interrupted by async reset at ph 5
    cpu_addr = 16'h2000; cpu_rnw = 1'b0;
    for (int i = 0; i < 5; i++) step("pre_rst", 1, 1, 0);
    chk("pre_rst/we_on", ram_we, 1'b1);
    #1;
    RESET = 1'b1;
    #1;
    chk_reset("async_rst");
    @(posedge clk); #1;
    chk_reset("rst_hold");
    RESET = 1'b0;
    n = 0;
    cyc("post_rst", 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
